// File: rtl/fb_arb_pkg.sv
// Shared state encoding and default burst-length width for the frame-buffer access arbiter.
package fb_arb_pkg;
  localparam int FB_ARB_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } fb_arb_state_t;
endpackage

// File: rtl/fb_arb_beat_cnt.sv
// Burst beat counter: loads AxLEN on grant, counts down per granted beat, saturates at zero.
// zero flag is a pure decode of the count register; no backpressure.
module fb_arb_beat_cnt
  import fb_arb_pkg::*;
#(
  parameter int LEN_W = FB_ARB_LEN_W
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LEN_W-1:0] cnt;

  // Hold at zero so a max-length burst never wraps back to a full count.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fb_access_arbiter.sv
// Grants the single frame-buffer port to the AXI write or read channel for one whole burst; 1-cycle grant latency.
// Ties are round-robin, or write-always-wins when FB_ARB_WR_PRIORITY_EN is defined; requests simply wait in IDLE.
module fb_access_arbiter
  import fb_arb_pkg::*;
#(
  parameter int LEN_W = FB_ARB_LEN_W
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             wr_req,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             wr_beat,
  input  logic             rd_req,
  input  logic [LEN_W-1:0] rd_len,
  input  logic             rd_beat,
  output logic             wr_gnt,
  output logic             rd_gnt,
  output logic             mem_sel,
  output logic             wr_done,
  output logic             rd_done,
  output logic             busy
);

  fb_arb_state_t state;

  logic             pick_wr;
  logic             pick_rd;
  logic             grant;
  logic             fire;
  logic             cnt_zero;
  logic [LEN_W-1:0] load_val;

`ifdef FB_ARB_WR_PRIORITY_EN
  assign pick_wr = wr_req;
`else
  logic last_rd;

  // Resets to "read" so the first tie after reset goes to the write channel.
  assign pick_wr = wr_req & (~rd_req | last_rd);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_rd <= 1'b1;
    end else if (grant) begin
      last_rd <= pick_rd;
    end
  end
`endif

  assign pick_rd  = rd_req & ~pick_wr;
  assign grant    = (state == IDLE) & (pick_wr | pick_rd);
  assign load_val = pick_wr ? wr_len : rd_len;
  assign fire     = (wr_gnt & wr_beat) | (rd_gnt & rd_beat);

  fb_arb_beat_cnt #(
    .LEN_W(LEN_W)
  ) u_beat_cnt (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .load    (grant),
    .load_val(load_val),
    .dec     (fire),
    .zero    (cnt_zero)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      wr_gnt  <= 1'b0;
      rd_gnt  <= 1'b0;
      mem_sel <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_wr) begin
            state   <= WR_BURST;
            wr_gnt  <= 1'b1;
            mem_sel <= 1'b0;
            busy    <= 1'b1;
          end else if (pick_rd) begin
            state   <= RD_BURST;
            rd_gnt  <= 1'b1;
            mem_sel <= 1'b1;
            busy    <= 1'b1;
          end
        end
        WR_BURST: begin
          if (wr_beat && cnt_zero) begin
            state  <= IDLE;
            wr_gnt <= 1'b0;
            busy   <= 1'b0;
          end
        end
        RD_BURST: begin
          if (rd_beat && cnt_zero) begin
            state  <= IDLE;
            rd_gnt <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          wr_gnt <= 1'b0;
          rd_gnt <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Done must coincide with the final beat, so it is the registered grant/zero state qualified by that beat.
  assign wr_done = wr_gnt & wr_beat & cnt_zero & ~ARESET;
  assign rd_done = rd_gnt & rd_beat & cnt_zero & ~ARESET;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter; inputs change on the falling edge, outputs are sampled 1ns later.
module tb_fb_access_arbiter;

  logic       ACLK;
  logic       ARESET;
  logic       wr_req;
  logic [7:0] wr_len;
  logic       wr_beat;
  logic       rd_req;
  logic [7:0] rd_len;
  logic       rd_beat;
  logic       wr_gnt;
  logic       rd_gnt;
  logic       mem_sel;
  logic       wr_done;
  logic       rd_done;
  logic       busy;

  int n_chk;
  int n_err;

  fb_access_arbiter #(
    .LEN_W(8)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .wr_req (wr_req),
    .wr_len (wr_len),
    .wr_beat(wr_beat),
    .rd_req (rd_req),
    .rd_len (rd_len),
    .rd_beat(rd_beat),
    .wr_gnt (wr_gnt),
    .rd_gnt (rd_gnt),
    .mem_sel(mem_sel),
    .wr_done(wr_done),
    .rd_done(rd_done),
    .busy   (busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Expected vector order: {wr_gnt, rd_gnt, mem_sel, wr_done, rd_done, busy}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {wr_gnt, rd_gnt, mem_sel, wr_done, rd_done, busy};
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int          wg_cnt;
    int          rg_cnt;
    int          wd_cnt;
    int          rdn_cnt;
    int          seen;
    logic        exp_g;
    logic        exp_d;
    logic [15:0] pat_r;
    logic [15:0] pat_w;

    n_chk   = 0;
    n_err   = 0;
    ARESET  = 1'b1;
    wr_req  = 1'b0;
    wr_len  = 8'd0;
    wr_beat = 1'b0;
    rd_req  = 1'b0;
    rd_len  = 8'd0;
    rd_beat = 1'b0;

    // Reset state
    repeat (2) @(negedge ACLK);
    #1 chk("reset", 6'b000000);
    ARESET = 1'b0;

    // Single write burst of 4 beats
    @(negedge ACLK);
    wr_req = 1'b1;
    wr_len = 8'd3;
    #1 chk("wr4_idle", 6'b000000);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      wr_req  = 1'b0;
      wr_beat = 1'b1;
      #1 chk("wr4_beat", {1'b1, 1'b0, 1'b0, (i == 3), 1'b0, 1'b1});
    end
    @(negedge ACLK);
    wr_beat = 1'b0;
    #1 chk("wr4_end", 6'b000000);

    // Simultaneous requests from reset, single-beat bursts, two rounds
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    wr_len = 8'd0;
    rd_len = 8'd0;
    #1 chk("tie_rst", 6'b000000);
    for (int r = 0; r < 2; r++) begin
      @(negedge ACLK);
      wr_req  = 1'b0;
      wr_beat = 1'b1;
      #1 chk("tie_wr", 6'b100101);
      @(negedge ACLK);
      wr_beat = 1'b0;
      #1 chk("tie_gap", 6'b000000);
      @(negedge ACLK);
      rd_req  = 1'b0;
      rd_beat = 1'b1;
      #1 chk("tie_rd", 6'b011011);
      @(negedge ACLK);
      rd_beat = 1'b0;
      if (r == 0) begin
        wr_req = 1'b1;
        rd_req = 1'b1;
      end
      #1 chk("tie_idle", 6'b001000);
    end

    // Continuous requests on both channels, len=1, beats every cycle
    @(negedge ACLK);
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    wr_len  = 8'd1;
    rd_len  = 8'd1;
    wr_beat = 1'b1;
    rd_beat = 1'b1;
    wg_cnt  = 0;
    rg_cnt  = 0;
    wd_cnt  = 0;
    rdn_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge ACLK);
      #1;
      wg_cnt  += int'(wr_gnt);
      rg_cnt  += int'(rd_gnt);
      wd_cnt  += int'(wr_done);
      rdn_cnt += int'(rd_done);
      chk_val("cont_overlap", int'(wr_gnt & rd_gnt), 0);
    end
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_beat = 1'b0;
    rd_beat = 1'b0;
`ifdef FB_ARB_WR_PRIORITY_EN
    chk_val("cont_wr_gnt", wg_cnt, 8);
    chk_val("cont_rd_gnt", rg_cnt, 0);
    chk_val("cont_wr_done", wd_cnt, 4);
    chk_val("cont_rd_done", rdn_cnt, 0);
`else
    chk_val("cont_wr_gnt", wg_cnt, 4);
    chk_val("cont_rd_gnt", rg_cnt, 4);
    chk_val("cont_wr_done", wd_cnt, 2);
    chk_val("cont_rd_done", rdn_cnt, 2);
`endif

    // Read burst of 8 with gapped beats and stray write beats
    @(negedge ACLK);
    rd_req = 1'b1;
    rd_len = 8'd7;
    pat_r  = 16'hFDCD;
    pat_w  = 16'hAAAA;
    seen   = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge ACLK);
      rd_req  = 1'b0;
      rd_beat = pat_r[i];
      wr_beat = pat_w[i];
      #1;
      exp_g = (seen < 8);
      exp_d = pat_r[i] && (seen == 7);
      chk("rd8_gap", {1'b0, exp_g, 1'b1, 1'b0, exp_d, exp_g});
      if (exp_g && pat_r[i]) seen++;
    end
    @(negedge ACLK);
    rd_beat = 1'b0;
    wr_beat = 1'b0;
    #1 chk("rd8_end", 6'b001000);

    // Reset in the middle of a 5-beat write burst
    @(negedge ACLK);
    wr_req = 1'b1;
    wr_len = 8'd4;
    @(negedge ACLK);
    wr_req  = 1'b0;
    wr_beat = 1'b1;
    #1 chk("abort_b1", 6'b100001);
    @(negedge ACLK);
    #1 chk("abort_b2", 6'b100001);
    @(negedge ACLK);
    ARESET  = 1'b1;
    wr_beat = 1'b0;
    #1 chk("abort_rst_cyc", 6'b100001);
    @(negedge ACLK);
    ARESET = 1'b0;
    rd_req = 1'b1;
    rd_len = 8'd0;
    #1 chk("abort_after", 6'b000000);
    @(negedge ACLK);
    rd_req  = 1'b0;
    rd_beat = 1'b1;
    #1 chk("abort_rd", 6'b011011);
    @(negedge ACLK);
    rd_beat = 1'b0;
    #1 chk("abort_idle", 6'b001000);

    // Maximum-length read burst: 256 beats
    @(negedge ACLK);
    rd_req = 1'b1;
    rd_len = 8'd255;
    for (int i = 0; i < 256; i++) begin
      @(negedge ACLK);
      rd_req  = 1'b0;
      rd_beat = 1'b1;
      #1 chk("rd256", {1'b0, 1'b1, 1'b1, 1'b0, (i == 255), 1'b1});
    end
    @(negedge ACLK);
    rd_beat = 1'b0;
    #1 chk("rd256_end", 6'b001000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
FB_ACCESS_ARBITER -- requirements
Module: fb_access_arbiter

Interface
REQ-001 Parameter: LEN_W, default 8, AXI burst-length field width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: ACLK in 1 (clock, all logic rising-edge); ARESET in 1 (synchronous active-high reset).
REQ-003 wr_req in 1: write-channel burst pending, held until wr_gnt is seen.
REQ-004 wr_len in LEN_W: AWLEN of the pending write burst, beats = wr_len+1.
REQ-005 wr_beat in 1: one write beat transferred to frame buffer this cycle.
REQ-006 rd_req in 1: read-channel burst pending, held until rd_gnt is seen.
REQ-007 rd_len in LEN_W: ARLEN of the pending read burst.
REQ-008 rd_beat in 1: one read beat taken from frame buffer this cycle.
REQ-009 wr_gnt out 1: write channel owns frame-buffer port.
REQ-010 rd_gnt out 1: read channel owns frame-buffer port.
REQ-011 mem_sel out 1: port mux select, 0 = write, 1 = read; holds last value in IDLE.
REQ-012 wr_done out 1 / rd_done out 1: one-cycle pulse on the final beat of a granted burst.
REQ-013 busy out 1: high in any non-IDLE state.

Function
REQ-014 FSM states SHALL be IDLE, WR_BURST, RD_BURST; all outputs registered.
REQ-015 IDLE with only wr_req: next state WR_BURST, wr_gnt=1 from next cycle (1-cycle grant latency); same for rd_req -> RD_BURST.
REQ-016 IDLE with both requests: grant the channel not granted last (round-robin); last-grant register resets to "read" so write wins first tie.
REQ-017 On grant, beat counter SHALL load the granted len; each granted-channel beat decrements it.
REQ-018 Beat with counter==0: assert matching done pulse same cycle, drop gnt and return to IDLE next cycle; IDLE lasts at least one cycle between bursts.
REQ-019 len=0 SHALL be a single-beat burst; len=2^LEN_W-1 SHALL be 2^LEN_W beats, counter never wraps.
REQ-020 Beats on the non-granted channel, or in IDLE, SHALL be ignored.
REQ-021 Request deassertion mid-burst SHALL be ignored; burst ends only by beat count.
REQ-022 wr_gnt and rd_gnt SHALL never be high together.

Reset
REQ-023 ARESET=1 at a rising edge: state IDLE, wr_gnt=rd_gnt=0, wr_done=rd_done=0, busy=0, mem_sel=0, counter=0, last-grant=read.
REQ-024 Reset mid-burst SHALL abort the burst with no done pulse; outputs at reset values the following cycle.

Configuration
REQ-025 Macro FB_ARB_WR_PRIORITY_EN defined: write SHALL win every simultaneous request (fixed priority, last-grant register removed); undefined: round-robin per REQ-016.

Structure
REQ-026 Package fb_arb_pkg SHALL hold the FSM state typedef (fb_arb_state_t) and the LEN_W default constant.
REQ-027 One sub-module, fb_arb_beat_cnt (load/decrement/zero-flag counter), SHALL be instantiated; the rest stays in fb_access_arbiter.

Verification
REQ-028 wr_req=1, wr_len=3, wr_beat every cycle after grant -> wr_gnt high 4 cycles, wr_done on 4th beat, busy low next cycle.
REQ-029 wr_req and rd_req both raised from reset, len=0 each -> write granted first, read granted after one IDLE cycle; repeat -> write then read again.
REQ-030 With FB_ARB_WR_PRIORITY_EN, continuous wr_req and rd_req, len=1 -> rd_gnt never asserted.
REQ-031 rd_gnt, rd_len=7, rd_beat with gaps plus stray wr_beat pulses -> exactly 8 rd_beats end burst, wr_beat ignored, gnts never overlap.
REQ-032 ARESET asserted after 2 of 5 beats of a write burst -> next cycle all outputs at reset, no wr_done; new rd_req then granted normally.
REQ-033 rd_len=255, rd_beat every cycle -> rd_done exactly on 256th beat.
